// File: rtl/reaction_controller_pkg.sv
// Shared types and constants for the reaction-time trial controller and its LFSR.
// Pure declarations; no latency, no flow control.
package reaction_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    LIT  = 2'b10
  } state_t;

  localparam int          RESULT_W          = 14;
  // Taps for x^16+x^14+x^13+x^11+1 in a shift-left Fibonacci register
  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/reaction_controller_if.sv
// Button/tick inputs and trial result outputs of the reaction controller.
// Level signals only; no handshake, consumer samples every clk.
interface reaction_if;
  import reaction_pkg::*;

  logic                tick_ms;
  logic                start;
  logic                stop;
  logic                led;
  logic                busy;
  logic [RESULT_W-1:0] result;
  logic                result_valid;
  logic                early;
  logic                timeout;

  modport master (
    output tick_ms, start, stop,
    input  led, busy, result, result_valid, early, timeout
  );

  modport slave (
    input  tick_ms, start, stop,
    output led, busy, result, result_valid, early, timeout
  );

endinterface

// File: rtl/reaction_controller_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, advances every clk outside reset.
// Output is the register itself; no backpressure.
module lfsr16
  import reaction_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] q_o
);

  logic [15:0] lfsr_q;

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= SEED;
    else     lfsr_q <= lfsr_next(lfsr_q);
  end

  assign q_o = lfsr_q;

endmodule

// File: rtl/reaction_controller.sv
// Reaction-time trial sequencer: random delay, LED, ms count until stop press.
// All outputs registered, one clk after the causing input; inputs never stalled.
module reaction_controller
  import reaction_pkg::*;
#(
  parameter int          MIN_DELAY_MS = 1000,
  parameter int          RAND_BITS    = 11,
  parameter int          MAX_RT_MS    = 9999,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input logic   clk,
  input logic   rst,
  reaction_if.slave bus
);

  if ((MIN_DELAY_MS + (1 << RAND_BITS) - 1 > 16383) || (MAX_RT_MS > 16383) ||
      (MIN_DELAY_MS < 1) || (RAND_BITS < 1) || (RAND_BITS > 14)) begin : g_bad_params
    $error("reaction_controller: delay or timeout parameters do not fit 14-bit counters");
  end

  localparam logic [RESULT_W-1:0] RT_MAX  = RESULT_W'(MAX_RT_MS);
  localparam logic [RESULT_W-1:0] RT_LAST = RESULT_W'(MAX_RT_MS - 1);
  localparam logic [RESULT_W-1:0] DLY_MIN = RESULT_W'(MIN_DELAY_MS);

  logic [15:0]         lfsr_q;
  logic                lfsr_unused;
  state_t              state_q;
  logic                start_q, stop_q;
  logic                led_q, busy_q, result_valid_q, early_q, timeout_q;
  logic [RESULT_W-1:0] result_q, delay_cnt_q, rt_cnt_q;
  logic [RESULT_W-1:0] delay_cnt_d;
  logic                start_rise, stop_rise;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q_o (lfsr_q)
  );

  assign lfsr_unused = ^lfsr_q;
  assign start_rise  = bus.start & ~start_q;
  assign stop_rise   = bus.stop & ~stop_q;
  assign delay_cnt_d = DLY_MIN + RESULT_W'(lfsr_q[RAND_BITS-1:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      start_q        <= 1'b0;
      stop_q         <= 1'b0;
      led_q          <= 1'b0;
      busy_q         <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      early_q        <= 1'b0;
      timeout_q      <= 1'b0;
      delay_cnt_q    <= '0;
      rt_cnt_q       <= '0;
    end else begin
      start_q <= bus.start;
      stop_q  <= bus.stop;
      case (state_q)
        IDLE: begin
          led_q  <= 1'b0;
          busy_q <= 1'b0;
          if (start_rise) begin
            delay_cnt_q    <= delay_cnt_d;
            result_valid_q <= 1'b0;
            early_q        <= 1'b0;
            timeout_q      <= 1'b0;
            busy_q         <= 1'b1;
            state_q        <= WAIT;
          end
        end
        WAIT: begin
          // Level test: a stop button already held at start is a false start
          if (bus.stop) begin
            early_q        <= 1'b1;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            state_q        <= IDLE;
          end else if (bus.tick_ms) begin
            if (delay_cnt_q == RESULT_W'(1)) begin
              rt_cnt_q <= '0;
              led_q    <= 1'b1;
              state_q  <= LIT;
            end else begin
              delay_cnt_q <= delay_cnt_q - RESULT_W'(1);
            end
          end
        end
        LIT: begin
          if (stop_rise) begin
            result_q       <= rt_cnt_q;
            result_valid_q <= 1'b1;
            led_q          <= 1'b0;
            busy_q         <= 1'b0;
            state_q        <= IDLE;
          end else if (bus.tick_ms) begin
            if (rt_cnt_q == RT_LAST) begin
              result_q       <= RT_MAX;
              timeout_q      <= 1'b1;
              result_valid_q <= 1'b1;
              led_q          <= 1'b0;
              busy_q         <= 1'b0;
              state_q        <= IDLE;
            end else begin
              rt_cnt_q <= rt_cnt_q + RESULT_W'(1);
            end
          end
        end
        default: begin
          state_q        <= IDLE;
          led_q          <= 1'b0;
          busy_q         <= 1'b0;
          result_q       <= '0;
          result_valid_q <= 1'b0;
          early_q        <= 1'b0;
          timeout_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.led          = led_q;
  assign bus.busy         = busy_q;
  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;
  assign bus.early        = early_q;
  assign bus.timeout      = timeout_q;

endmodule

// File: tb/tb_reaction_controller.sv
// Scoreboard bench for reaction_controller with a small delay/timeout configuration.
module tb_reaction_controller;
  import reaction_pkg::*;

  localparam int          MIN   = 4;
  localparam int          RB    = 2;
  localparam int          MAXRT = 50;
  localparam logic [15:0] SEED  = 16'hACE1;

  typedef struct {
    logic [13:0] result;
    logic        vld;
    logic        early;
    logic        tmo;
  } end_t;

  logic clk = 1'b0;
  logic rst;
  reaction_if bus();

  reaction_controller #(
    .MIN_DELAY_MS (MIN),
    .RAND_BITS    (RB),
    .MAX_RT_MS    (MAXRT),
    .LFSR_SEED    (SEED)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   tests = 0;
  int   fails = 0;
  end_t exp_end[$];
  int   exp_led[$];
  logic [15:0] m_lfsr;
  logic [13:0] m_result = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Independent LFSR model, x^16+x^14+x^13+x^11+1
  always @(posedge clk) begin
    if (rst) m_lfsr <= SEED;
    else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  // tick_ms every 3rd cycle, changed just after posedge
  initial begin
    int tph = 0;
    bus.tick_ms = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.tick_ms = (tph == 0);
      tph = (tph == 2) ? 0 : tph + 1;
    end
  end

  // Monitor: pops expectations on trial start, LED rise and trial end
  initial begin
    bit   prev_busy = 1'b0;
    bit   prev_led  = 1'b0;
    int   wait_ticks = 0;
    int   n;
    end_t e;
    forever begin
      @(negedge clk);
      if (bus.busy === 1'b1 && !prev_busy) begin
        wait_ticks = 0;
        check("start_clr_early", 32'(bus.early), 32'd0);
        check("start_clr_tmo", 32'(bus.timeout), 32'd0);
        check("start_clr_vld", 32'(bus.result_valid), 32'd0);
        check("start_result_held", 32'(bus.result), 32'(m_result));
        check("lfsr_track", 32'(dut.lfsr_q), 32'(m_lfsr));
      end
      if (bus.led === 1'b1 && !prev_led) begin
        if (exp_led.size() == 0) begin
          check("led_unexpected", 32'(bus.led), 32'd0);
        end else begin
          n = exp_led.pop_front();
          check("led_delay_ticks", 32'(wait_ticks), 32'(n));
        end
      end
      if (bus.busy === 1'b0 && prev_busy) begin
        check("end_led_low", 32'(bus.led), 32'd0);
        if (exp_end.size() == 0) begin
          check("end_unexpected", 32'(bus.busy), 32'd1);
        end else begin
          e = exp_end.pop_front();
          m_result = e.result;
          check("end_result", 32'(bus.result), 32'(e.result));
          check("end_valid", 32'(bus.result_valid), 32'(e.vld));
          check("end_early", 32'(bus.early), 32'(e.early));
          check("end_timeout", 32'(bus.timeout), 32'(e.tmo));
        end
      end
      if (bus.busy === 1'b1 && bus.led === 1'b0 && bus.tick_ms === 1'b1) wait_ticks++;
      prev_busy = (bus.busy === 1'b1);
      prev_led  = (bus.led === 1'b1);
    end
  end

  task automatic press_start(input bit expect_led);
    @(negedge clk);
    bus.start = 1'b1;
    if (expect_led) exp_led.push_back(MIN + int'(m_lfsr[RB-1:0]));
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_led(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bus.led === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check("led_wait_timeout", 32'(bus.led), 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bus.busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check("idle_wait_timeout", 32'(bus.busy), 32'd0);
  endtask

  // After the LED, let n ticks count, optionally line stop up with the next tick
  task automatic lit_stop(input int n, input bit align);
    bit ok;
    int k = 0;
    wait_led(ok);
    if (!ok) return;
    while (k < n) begin
      if (bus.tick_ms === 1'b1) k++;
      @(negedge clk);
    end
    if (align) begin
      for (int i = 0; i < 4 && bus.tick_ms !== 1'b1; i++) @(negedge clk);
    end
    exp_end.push_back('{result: 14'(n), vld: 1'b1, early: 1'b0, tmo: 1'b0});
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
  endtask

  initial begin
    bit ok;
    int k;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.stop  = 1'b0;

    // Reset with buttons wiggling
    @(negedge clk);
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    check("rst_led", 32'(bus.led), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_valid", 32'(bus.result_valid), 32'd0);
    check("rst_early", 32'(bus.early), 32'd0);
    check("rst_timeout", 32'(bus.timeout), 32'd0);
    check("rst_lfsr_seed", 32'(dut.lfsr_q), 32'hACE1);
    rst = 1'b0;
    bus.stop = 1'b0;
    @(negedge clk);
    check("lfsr_first_step", 32'(dut.lfsr_q), 32'(m_lfsr));
    repeat (2) @(negedge clk);

    // Normal trial, 25 ms reaction
    press_start(1'b1);
    lit_stop(25, 1'b0);
    wait_idle(20);
    repeat (3) @(negedge clk);

    // False start after 2 ticks
    press_start(1'b0);
    exp_end.push_back('{result: 14'd0, vld: 1'b0, early: 1'b1, tmo: 1'b0});
    k = 0;
    while (k < 2) begin
      if (bus.tick_ms === 1'b1) k++;
      @(negedge clk);
    end
    bus.stop = 1'b1;
    wait_idle(20);
    repeat (2) @(negedge clk);
    bus.stop = 1'b0;
    repeat (2) @(negedge clk);

    // Timeout after 50 ticks lit
    press_start(1'b1);
    exp_end.push_back('{result: 14'd50, vld: 1'b1, early: 1'b0, tmo: 1'b1});
    @(negedge clk);
    wait_idle(400);
    repeat (3) @(negedge clk);

    // Stop and tick in the same cycle with rt_cnt at 12
    press_start(1'b1);
    lit_stop(12, 1'b1);
    wait_idle(20);
    repeat (3) @(negedge clk);

    // Reset while lit
    press_start(1'b1);
    wait_led(ok);
    repeat (2) @(negedge clk);
    exp_end.push_back('{result: 14'd0, vld: 1'b0, early: 1'b0, tmo: 1'b0});
    rst = 1'b1;
    @(negedge clk);
    check("midrst_led", 32'(bus.led), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Start re-pressed during WAIT must not redraw the delay
    press_start(1'b1);
    repeat (2) @(negedge clk);
    check("repress_in_wait", 32'(bus.busy & ~bus.led), 32'd1);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    lit_stop(5, 1'b0);
    wait_idle(20);
    repeat (4) @(negedge clk);

    check("led_queue_drained", 32'(exp_led.size()), 32'd0);
    check("end_queue_drained", 32'(exp_end.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reaction_controller.md
Name: reaction_controller

Overview:
- Sequences one reaction-time trial: on a start press it waits a pseudo-random delay, lights the stimulus LED, then counts milliseconds until the stop press.
- Flags false starts and timeouts.
- Sits between the debounced/synchronised buttons, the 1 ms tick generator and the 14-bit result display path.

Parameters:
- MIN_DELAY_MS, 1000, fixed part of the pre-stimulus delay in ms.
- RAND_BITS, 11, width of the random part added to MIN_DELAY_MS; random range 0..2^RAND_BITS-1.
- MAX_RT_MS, 9999, reaction count saturation and timeout value.
- LFSR_SEED, 16'hACE1, non-zero LFSR reset value.

Ports:
- clk  in  1  system clock, single clock domain.
- rst  in  1  synchronous active-high reset.
- tick_ms  in  1  one-cycle enable pulse, once per millisecond.
- start  in  1  synchronised, debounced start button (level).
- stop  in  1  synchronised, debounced reaction button (level).
- led  out  1  stimulus LED, high while the reaction is being timed.
- busy  out  1  high in WAIT and LIT.
- result  out  14  last reaction time in ms; held until the next trial starts.
- result_valid  out  1  high when result holds a completed measurement.
- early  out  1  false start on the last trial.
- timeout  out  1  last trial saturated at MAX_RT_MS.

Behaviour:
- All outputs and state are registered. rst forces the following on the next edge: state IDLE, led=0, busy=0, result=0, result_valid=0, early=0, timeout=0, lfsr=LFSR_SEED, delay_cnt=0, rt_cnt=0.
- A reset mid-trial aborts the trial with the same values.
- Edge detect: start_q and stop_q are registered copies. start_rise = start & ~start_q; stop_rise = stop & ~stop_q. Both are cleared by rst.
- LFSR: 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1. It shifts every clk cycle, unconditionally, except during reset.
- IDLE: busy=0, led=0.
  - On start_rise: delay_cnt <= MIN_DELAY_MS + lfsr[RAND_BITS-1:0], using the lfsr value sampled that cycle.
  - Also clears result_valid, early and timeout; goes to WAIT.
  - result is unchanged until a new measurement completes.
- WAIT: busy=1, led=0.
  - Priority 1, stop==1 (level, so a button already held counts): early<=1, result<=0, result_valid<=0, go to IDLE.
  - Priority 2, tick_ms: if delay_cnt==1, rt_cnt<=0 and go to LIT; otherwise delay_cnt decrements.
  - The LED therefore rises on the edge after the Nth tick, N = MIN_DELAY_MS + random.
- LIT: busy=1, led=1.
  - Priority 1, stop_rise: result<=rt_cnt (value before any same-cycle increment), result_valid<=1, go to IDLE. led falls on the same edge.
  - Priority 2, tick_ms:
    - If rt_cnt==MAX_RT_MS-1: result<=MAX_RT_MS, timeout<=1, result_valid<=1, go to IDLE.
    - Otherwise rt_cnt increments.
- start_rise in WAIT or LIT is ignored. The start level has no effect outside IDLE.
- Widths:
  - delay_cnt and rt_cnt are 14 bits.
  - MIN_DELAY_MS + 2^RAND_BITS - 1 must be ≤ 16383, and MAX_RT_MS must be ≤ 16383. Check both with an elaboration-time assertion.
  - MIN_DELAY_MS must be ≥ 1.
- State encoding is 2 bits. The unused code returns to IDLE with all outputs cleared.

Decomposition:
- Shared package reaction_pkg:
  - state enum IDLE/WAIT/LIT.
  - RESULT_W = 14.
  - LFSR tap mask constant.
  - Default LFSR seed.
- Sub-module lfsr16: clk, rst, seed parameter, 16-bit q output, free-running. It is reusable by other random-event blocks.
- Edge detection and the FSM stay in reaction_controller.

Test Plan:
All tests use a bench configuration of MIN_DELAY_MS=4, RAND_BITS=2, MAX_RT_MS=50, tick_ms pulsed every 3rd cycle, and a bench LFSR model.
1. Reset: hold rst 2 cycles with start/stop toggling -> led=0, busy=0, result=0, result_valid=0, early=0, timeout=0; lfsr == 16'hACE1 after release.
2. Normal trial: start rise -> led rises after exactly 4+model[1:0] ticks; 25 ticks later, stop rise -> result=25, result_valid=1, led=0, busy=0 one edge later.
3. False start: start rise, stop held high after 2 ticks -> early=1, result=0, result_valid=0, led never asserted; a later start rise clears early.
4. Timeout: start rise, no stop -> after the 50th tick in LIT, result=50, timeout=1, result_valid=1, led=0.
5. Simultaneous: in LIT with rt_cnt=12, stop_rise and tick_ms on the same cycle -> result=12, not 13.
6. Robustness:
   - rst asserted mid-LIT -> led=0 and busy=0 on the next edge.
   - A start re-pressed during WAIT does not restart delay_cnt; the LED time matches the original draw.
